// File: rtl/aes_pkg.sv
// AES-128 shared types and GF(2^8) helpers.
// S-boxes are built from the field inverse plus the affine map.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND
  } state_e;

  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] b,
    input int         n
  );
    return (b << n) | (b >> (8 - n));
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] t;
    t = gmul(a, a);
    r = t;
    for (int i = 0; i < 6; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2)
             ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl8(b, 1) ^ rotl8(b, 3)
              ^ rotl8(b, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [7:0]   b   [16];
  logic [7:0]   s   [16];
  logic [127:0] ark;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    ark = '0;
    for (int k = 0; k < 16; k++) begin
      b[k] = state_i[127-8*k -: 8];
    end
    // Byte (row r, col c) comes from col c-r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[r+4*c] = inv_sbox(b[r+4*((c-r+4)%4)]);
      end
    end
    for (int k = 0; k < 16; k++) begin
      ark[127-8*k -: 8] = s[k];
    end
    ark = ark ^ rkey_i;
    state_o = ark;
    if (!last_i) begin
      for (int c = 0; c < 4; c++) begin
        a0 = ark[127-32*c -: 8];
        a1 = ark[119-32*c -: 8];
        a2 = ark[111-32*c -: 8];
        a3 = ark[103-32*c -: 8];
        state_o[127-32*c -: 8] = gmul(a0, 8'h0e)
          ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        state_o[119-32*c -: 8] = gmul(a0, 8'h09)
          ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        state_o[111-32*c -: 8] = gmul(a0, 8'h0d)
          ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        state_o[103-32*c -: 8] = gmul(a0, 8'h0b)
          ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end else begin
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
    end
  end

endmodule

// File: rtl/aes_decryption.sv
// Iterative AES-128 decryptor: expands all round keys first,
// then runs ten inverse rounds, one per clock.
module aes_decryption
  import aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [127:0] cypher,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] NR = 4'(ROUNDS);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  block_t       ct_q, ct_d;
  block_t       st_q, st_d;
  block_t       pt_q, pt_d;
  block_t       rk_q [0:10];
  block_t       rk_d [0:10];
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [3:0]   kidx;
  block_t       prev_rk, next_rk, sel_rk, rnd_out;
  logic [31:0]  rot, tmp;
  logic [31:0]  n0, n1, n2, n3;

  aes_inv_round u_round (
    .state_i (st_q),
    .rkey_i  (sel_rk),
    .last_i  (cnt_q == 4'd0),
    .state_o (rnd_out)
  );

  always_comb begin
    kidx    = cnt_q - 4'd1;
    prev_rk = (cnt_q != 4'd0 && cnt_q <= NR) ? rk_q[kidx] : '0;
    sel_rk  = (cnt_q <= NR) ? rk_q[cnt_q] : '0;
    rot     = {prev_rk[23:0], prev_rk[31:24]};
    tmp     = {sbox(rot[31:24]), sbox(rot[23:16]),
               sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {(cnt_q <= NR) ? RCON[cnt_q] : 8'h00, 24'h0};
    n0      = prev_rk[127:96] ^ tmp;
    n1      = prev_rk[95:64] ^ n0;
    n2      = prev_rk[63:32] ^ n1;
    n3      = prev_rk[31:0] ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    st_d    = st_q;
    pt_d    = pt_q;
    rk_d    = rk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          ct_d    = cypher;
          rk_d[0] = key;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          state_d = KEYEXP;
        end
      end
      KEYEXP: begin
        if (cnt_q <= NR) rk_d[cnt_q] = next_rk;
        if (cnt_q == NR) begin
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      INIT: begin
        st_d    = ct_q ^ rk_q[10];
        cnt_d   = NR - 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        st_d = rnd_out;
        if (cnt_q == 4'd0) begin
          pt_d    = rnd_out;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ct_q    <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i <= 10; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign plaintext = pt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_decryption.sv
// Directed bench for aes_decryption: known-answer vectors,
// latency, ignored enable, mid-operation reset, back-to-back.
module tb_aes_decryption;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [127:0] cypher;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  aes_decryption #(.ROUNDS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cypher    (cypher),
    .key       (key),
    .plaintext (plaintext),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic start(input vec_t v);
    @(negedge clk);
    key    = v.key;
    cypher = v.ct;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    key    = ~v.key;
    cypher = ~v.ct;
  endtask

  // lat counts edges after the accepting edge; -1 on timeout.
  task automatic wait_done(
    input  logic [127:0] pt_before,
    output int           lat,
    output bit           pt_moved,
    output bit           busy_gap
  );
    lat      = -1;
    pt_moved = 1'b0;
    busy_gap = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (plaintext !== pt_before) pt_moved = 1'b1;
      if (busy !== 1'b1) busy_gap = 1'b1;
    end
  endtask

  task automatic run_vec(
    input string        name,
    input vec_t         v,
    input logic [127:0] pt_before
  );
    int lat;
    bit moved, gap;
    start(v);
    chk({name, "_busy_start"}, 128'(busy), 128'(1));
    wait_done(pt_before, lat, moved, gap);
    chk({name, "_latency"}, 128'(lat), 128'(21));
    chk({name, "_plaintext"}, plaintext, v.pt);
    chk({name, "_busy_at_done"}, 128'(busy), 128'(0));
    chk({name, "_pt_stable"}, 128'(moved), 128'(0));
    chk({name, "_busy_held"}, 128'(gap), 128'(0));
    @(posedge clk);
    #1;
    chk({name, "_done_1cyc"}, 128'(done), 128'(0));
  endtask

  initial begin
    int   lat, nd, exp_k;
    bit   moved, gap;
    logic [127:0] prev;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'h0};

    reset  = 1'b1;
    enable = 1'b0;
    key    = '0;
    cypher = '0;
    @(negedge clk);
    chk("rst_plaintext", plaintext, 128'h0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    key    = vecs[0].key;
    cypher = vecs[0].ct;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    chk("enable_in_reset_ignored", 128'(busy), 128'(0));

    prev = 128'h0;
    for (int i = 0; i < 3; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], prev);
      prev = vecs[i].pt;
    end

    // Enable during busy must be ignored.
    start(vecs[0]);
    repeat (4) @(posedge clk);
    #1;
    key    = vecs[1].key;
    cypher = vecs[1].ct;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_done(prev, lat, moved, gap);
    chk("ign_latency", 128'(lat), 128'(16));
    chk("ign_plaintext", plaintext, vecs[0].pt);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("ign_no_extra_done", 128'(nd), 128'(0));

    // Reset in the middle of an operation.
    start(vecs[0]);
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_plaintext", plaintext, 128'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("midrst_aborted", 128'(nd), 128'(0));
    run_vec("postrst", vecs[1], 128'h0);

    // Enable held high: back-to-back runs every 22 cycles.
    @(negedge clk);
    key    = vecs[0].key;
    cypher = vecs[0].ct;
    enable = 1'b1;
    @(posedge clk);
    #1;
    nd = 0;
    for (int k = 1; k <= 66; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        exp_k = 21 + 22 * (nd - 1);
        chk($sformatf("b2b_done%0d_cycle", nd),
            128'(k), 128'(exp_k));
        chk($sformatf("b2b_done%0d_pt", nd),
            plaintext, vecs[0].pt);
      end
    end
    enable = 1'b0;
    chk("b2b_done_count", 128'(nd), 128'(3));
    wait_done(vecs[0].pt, lat, moved, gap);
    chk("b2b_drain_done", 128'(lat > 0), 128'(1));
    chk("b2b_drain_pt", plaintext, vecs[0].pt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
